// File: rtl/core_data_arbiter_pkg.sv
// Shared types and constants for the two-port core data arbiter.
package core_data_arbiter_pkg;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } arb_state_e;

  localparam logic PORT_CORE  = 1'b0;
  localparam logic PORT_DBG   = 1'b1;
  localparam int   DATA_WIDTH = 32;
  localparam int   BE_WIDTH   = 4;

endpackage

// File: rtl/core_data_arbiter_if.sv
// Core-style data port bundle (req/gnt/rvalid); master issues requests, slave answers.
interface core_data_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                                       req;
  logic                                       gnt;
  logic                                       rvalid;
  logic [ADDR_WIDTH-1:0]                      addr;
  logic                                       we;
  logic [core_data_arbiter_pkg::BE_WIDTH-1:0]   be;
  logic [core_data_arbiter_pkg::DATA_WIDTH-1:0] wdata;
  logic [core_data_arbiter_pkg::DATA_WIDTH-1:0] rdata;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/core_data_arbiter_rr2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the rr pointer.
module core_arb_rr2
  import core_data_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_rr,
  output logic       o_sel,
  output logic       o_valid
);

  always_comb begin
    o_valid = |i_req;
    case (i_req)
      2'b01:   o_sel = PORT_CORE;
      2'b10:   o_sel = PORT_DBG;
      2'b11:   o_sel = i_rr;
      default: o_sel = PORT_CORE;
    endcase
  end

endmodule

// File: rtl/core_data_arbiter.sv
// Shares one downstream core data port between the LSU (m0) and debug/DMA (m1).
//
// state    | meaning
// UNLOCKED | selection follows the round-robin pick combinationally
// LOCKED   | downstream saw a request without grant; selection held on r_owner
module core_data_arbiter
  import core_data_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int NUM_OUTSTANDING = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  core_data_arbiter_if.slave  m0_if,
  core_data_arbiter_if.slave  m1_if,
  core_data_arbiter_if.master s_if
);

  if (NUM_OUTSTANDING != 1) begin : g_bad_outstanding
    $error("core_data_arbiter tracks exactly one outstanding response");
  end

  arb_state_e            r_state;
  logic                  r_owner;
  logic                  r_rr;
  logic                  r_rsp_pending;
  logic                  r_rsp_owner;

  logic                  w_pick_sel;
  logic                  w_pick_valid;
  logic                  w_owner_req;
  logic                  w_sel;
  logic                  w_s_req;
  logic [ADDR_WIDTH-1:0] w_addr;

  core_arb_rr2 u_rr2 (
    .i_req   ({m1_if.req, m0_if.req}),
    .i_rr    (r_rr),
    .o_sel   (w_pick_sel),
    .o_valid (w_pick_valid)
  );

  always_comb begin
    w_owner_req = (r_owner == PORT_DBG) ? m1_if.req : m0_if.req;
    if (r_state == LOCKED) begin
      w_sel   = r_owner;
      w_s_req = w_owner_req;
    end else begin
      w_sel   = w_pick_sel;
      w_s_req = w_pick_valid;
    end
  end

  assign w_addr     = (w_sel == PORT_DBG) ? m1_if.addr : m0_if.addr;
  assign s_if.addr  = w_addr;
  assign s_if.we    = (w_sel == PORT_DBG) ? m1_if.we    : m0_if.we;
  assign s_if.be    = (w_sel == PORT_DBG) ? m1_if.be    : m0_if.be;
  assign s_if.wdata = (w_sel == PORT_DBG) ? m1_if.wdata : m0_if.wdata;

  // Handshake outputs are gated by rst_n so they drop the moment reset asserts.
  assign s_if.req     = rst_n & w_s_req;
  assign m0_if.gnt    = rst_n & s_if.gnt & (w_sel == PORT_CORE);
  assign m1_if.gnt    = rst_n & s_if.gnt & (w_sel == PORT_DBG);
  assign m0_if.rvalid = rst_n & s_if.rvalid & r_rsp_pending & (r_rsp_owner == PORT_CORE);
  assign m1_if.rvalid = rst_n & s_if.rvalid & r_rsp_pending & (r_rsp_owner == PORT_DBG);
  assign m0_if.rdata  = s_if.rdata;
  assign m1_if.rdata  = s_if.rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= UNLOCKED;
      r_owner       <= PORT_CORE;
      r_rr          <= PORT_CORE;
      r_rsp_pending <= 1'b0;
      r_rsp_owner   <= PORT_CORE;
    end else begin
      case (r_state)
        UNLOCKED: begin
          if (w_s_req && !s_if.gnt) begin
            r_state <= LOCKED;
            r_owner <= w_sel;
          end
        end
        LOCKED: begin
          if (s_if.gnt || !w_owner_req) begin
            r_state <= UNLOCKED;
          end
        end
      endcase

      // A same-cycle rvalid was already routed with the old owner; the grant reloads it.
      if (s_if.gnt) begin
        r_rr          <= ~w_sel;
        r_rsp_owner   <= w_sel;
        r_rsp_pending <= 1'b1;
      end else if (s_if.rvalid) begin
        r_rsp_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_core_data_arbiter.sv
// Self-checking bench for core_data_arbiter: directed scenarios plus random traffic vs a queue model.
module tb_core_data_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  core_data_arbiter_if #(.ADDR_WIDTH(32)) m0_bus ();
  core_data_arbiter_if #(.ADDR_WIDTH(32)) m1_bus ();
  core_data_arbiter_if #(.ADDR_WIDTH(32)) s_bus ();

  core_data_arbiter #(.ADDR_WIDTH(32), .NUM_OUTSTANDING(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m0_if (m0_bus),
    .m1_if (m1_bus),
    .s_if  (s_bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: who holds the downstream (-1 = nobody), who wins a tie,
  // and a FIFO of ports owed a response.
  int lock_own = -1;
  int prio     = 0;
  int rsp_q[$];

  int          e_sel;
  logic        e_sreq, e_we, e_gnt0, e_gnt1, e_rv0, e_rv1;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_be;

  task automatic model_eval();
    bit r0, r1;
    r0 = m0_bus.req;
    r1 = m1_bus.req;
    if (lock_own >= 0)    e_sel = lock_own;
    else if (r0 && r1)    e_sel = prio;
    else                  e_sel = r1 ? 1 : 0;
    e_sreq  = rst_n && ((e_sel == 1) ? r1 : r0);
    e_addr  = (e_sel == 1) ? m1_bus.addr  : m0_bus.addr;
    e_we    = (e_sel == 1) ? m1_bus.we    : m0_bus.we;
    e_be    = (e_sel == 1) ? m1_bus.be    : m0_bus.be;
    e_wdata = (e_sel == 1) ? m1_bus.wdata : m0_bus.wdata;
    e_gnt0  = rst_n && s_bus.gnt && (e_sel == 0);
    e_gnt1  = rst_n && s_bus.gnt && (e_sel == 1);
    e_rv0   = rst_n && s_bus.rvalid && (rsp_q.size() > 0) && (rsp_q[0] == 0);
    e_rv1   = rst_n && s_bus.rvalid && (rsp_q.size() > 0) && (rsp_q[0] == 1);
    if (rst_n && s_bus.rvalid && rsp_q.size() == 0) begin
      bad++;
      $display("FAIL rvalid_without_pending t=%0t got=rvalid want=no_rvalid", $time);
    end
  endtask

  task automatic model_clock();
    bit own_req;
    if (!rst_n) begin
      lock_own = -1;
      prio     = 0;
      rsp_q.delete();
      return;
    end
    if (s_bus.rvalid && rsp_q.size() > 0) void'(rsp_q.pop_front());
    if (s_bus.gnt) begin
      prio = 1 - e_sel;
      rsp_q.push_back(e_sel);
    end
    if (lock_own < 0) begin
      if (e_sreq && !s_bus.gnt) lock_own = e_sel;
    end else begin
      own_req = (lock_own == 1) ? m1_bus.req : m0_bus.req;
      if (s_bus.gnt || !own_req) lock_own = -1;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input bit req, input logic [31:0] addr, input bit we,
                          input logic [3:0] be, input logic [31:0] wdata);
    if (p == 0) begin
      m0_bus.req = req; m0_bus.addr = addr; m0_bus.we = we; m0_bus.be = be; m0_bus.wdata = wdata;
    end else begin
      m1_bus.req = req; m1_bus.addr = addr; m1_bus.we = we; m1_bus.be = be; m1_bus.wdata = wdata;
    end
  endtask

  task automatic idle_all();
    set_port(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    set_port(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    s_bus.gnt    = 1'b0;
    s_bus.rvalid = 1'b0;
    s_bus.rdata  = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_all();
    model_clock();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_all();
    set_port(0, 1'b1, 32'h1111_0000, 1'b0, 4'hF, 32'h0);
    set_port(1, 1'b1, 32'h2222_0000, 1'b1, 4'hF, 32'h0);
    s_bus.gnt = 1'b1;
    s_bus.rvalid = 1'b1;
    sample();
    total++;
    if ({s_bus.req, m0_bus.gnt, m1_bus.gnt, m0_bus.rvalid, m1_bus.rvalid} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=00000",
               {s_bus.req, m0_bus.gnt, m1_bus.gnt, m0_bus.rvalid, m1_bus.rvalid});
    end
    do_reset();
    sample();
    total++;
    if (s_bus.req !== 1'b0 || s_bus.addr !== 32'h0) begin
      bad++;
      $display("FAIL reset_idle got req=%b addr=%h want req=0 addr=0", s_bus.req, s_bus.addr);
    end
    advance();
  endtask

  task automatic test_single_m0();
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      if (c < 4) set_port(0, 1'b1, 32'h1A10_0000, 1'b0, 4'hF, 32'h0);
      else       set_port(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      s_bus.gnt    = (c == 3);
      s_bus.rvalid = (c == 4);
      s_bus.rdata  = (c == 4) ? 32'hDEAD_BEEF : 32'h0;
      sample();
      if (c <= 3) begin
        total++;
        if (s_bus.req !== 1'b1 || s_bus.addr !== 32'h1A10_0000) begin
          bad++;
          $display("FAIL single_addr c=%0d got req=%b addr=%h want req=1 addr=1a100000",
                   c, s_bus.req, s_bus.addr);
        end
      end
      total++;
      if (m0_bus.gnt !== (c == 3) || m0_bus.gnt !== e_gnt0) begin
        bad++;
        $display("FAIL single_gnt c=%0d got=%b want=%b", c, m0_bus.gnt, (c == 3));
      end
      total++;
      if ({m1_bus.gnt, m1_bus.rvalid} !== 2'b00) begin
        bad++;
        $display("FAIL single_m1_quiet c=%0d got=%b want=00", c, {m1_bus.gnt, m1_bus.rvalid});
      end
      if (c == 4) begin
        total++;
        if (m0_bus.rvalid !== 1'b1 || m0_bus.rdata !== 32'hDEAD_BEEF) begin
          bad++;
          $display("FAIL single_rsp got rvalid=%b rdata=%h want rvalid=1 rdata=deadbeef",
                   m0_bus.rvalid, m0_bus.rdata);
        end
      end
      advance();
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_rv;
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      set_port(0, 1'b1, 32'h1000_0000, 1'b0, 4'hF, 32'h0);
      set_port(1, 1'b1, 32'h2000_0000, 1'b0, 4'hF, 32'h0);
      s_bus.gnt    = (c % 3 == 2);
      s_bus.rvalid = (c % 3 == 0) && (c > 0);
      s_bus.rdata  = 32'hA000_0000 + c;
      sample();
      if (m0_bus.gnt) order.push_back(0);
      if (m1_bus.gnt) order.push_back(1);
      total++;
      if (s_bus.addr !== e_addr || s_bus.req !== e_sreq) begin
        bad++;
        $display("FAIL rr_select c=%0d got addr=%h want addr=%h", c, s_bus.addr, e_addr);
      end
      if (s_bus.rvalid) begin
        exp_rv = ((c / 3) - 1) % 2;
        total++;
        if ({m1_bus.rvalid, m0_bus.rvalid} !== ((exp_rv == 1) ? 2'b10 : 2'b01) ||
            {m1_bus.rvalid, m0_bus.rvalid} !== {e_rv1, e_rv0}) begin
          bad++;
          $display("FAIL rr_rvalid c=%0d got=%b want_port=%0d", c, {m1_bus.rvalid, m0_bus.rvalid}, exp_rv);
        end
      end
      advance();
    end
    total++;
    if (order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 0 || order[3] != 1) begin
      bad++;
      $display("FAIL rr_order got=%p want='{0,1,0,1}", order);
    end
  endtask

  task automatic test_lock_hold();
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      set_port(0, (c <= 5), 32'h0000_A000, 1'b0, 4'hF, 32'h0);
      set_port(1, (c >= 2 && c <= 7), 32'h0000_B000, 1'b0, 4'hF, 32'h0);
      s_bus.gnt    = (c == 5) || (c == 7);
      s_bus.rvalid = (c == 6) || (c == 8);
      sample();
      if (c <= 5) begin
        total++;
        if (s_bus.addr !== 32'h0000_A000) begin
          bad++;
          $display("FAIL lock_addr c=%0d got=%h want=0000a000", c, s_bus.addr);
        end
      end
      total++;
      if ({m1_bus.gnt, m0_bus.gnt} !== {(c == 7), (c == 5)}) begin
        bad++;
        $display("FAIL lock_gnt c=%0d got=%b want=%b", c, {m1_bus.gnt, m0_bus.gnt}, {(c == 7), (c == 5)});
      end
      if (c == 8) begin
        total++;
        if (m1_bus.rvalid !== 1'b1 || m0_bus.rvalid !== 1'b0) begin
          bad++;
          $display("FAIL lock_rsp got m1_rvalid=%b m0_rvalid=%b want 1 0", m1_bus.rvalid, m0_bus.rvalid);
        end
      end
      advance();
    end
  endtask

  task automatic test_same_cycle_write();
    do_reset();
    set_port(1, 1'b1, 32'h0000_0C00, 1'b1, 4'b0011, 32'h0000_55AA);
    s_bus.gnt = 1'b1;
    sample();
    total++;
    if (s_bus.we !== 1'b1 || s_bus.be !== 4'b0011 || s_bus.wdata !== 32'h0000_55AA) begin
      bad++;
      $display("FAIL sc_write_mux got we=%b be=%b wdata=%h want we=1 be=0011 wdata=000055aa",
               s_bus.we, s_bus.be, s_bus.wdata);
    end
    total++;
    if ({m1_bus.gnt, m0_bus.gnt} !== 2'b10) begin
      bad++;
      $display("FAIL sc_gnt got=%b want=10", {m1_bus.gnt, m0_bus.gnt});
    end
    advance();
    set_port(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    set_port(0, 1'b1, 32'h0000_0D00, 1'b0, 4'hF, 32'h0);
    s_bus.gnt = 1'b0;
    s_bus.rvalid = 1'b1;
    sample();
    total++;
    if (m1_bus.rvalid !== 1'b1 || m0_bus.rvalid !== 1'b0) begin
      bad++;
      $display("FAIL sc_rsp got m1_rvalid=%b m0_rvalid=%b want 1 0", m1_bus.rvalid, m0_bus.rvalid);
    end
    total++;
    if (s_bus.req !== 1'b1 || s_bus.addr !== 32'h0000_0D00) begin
      bad++;
      $display("FAIL sc_no_lock got req=%b addr=%h want req=1 addr=00000d00", s_bus.req, s_bus.addr);
    end
    advance();
    idle_all();
    sample();
    advance();
  endtask

  task automatic test_gnt_rvalid_overlap();
    do_reset();
    set_port(0, 1'b1, 32'h0000_E000, 1'b0, 4'hF, 32'h0);
    s_bus.gnt = 1'b1;
    sample();
    advance();
    set_port(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    set_port(1, 1'b1, 32'h0000_F000, 1'b0, 4'hF, 32'h0);
    s_bus.rvalid = 1'b1;
    s_bus.rdata  = 32'h1234_5678;
    sample();
    total++;
    if ({m1_bus.rvalid, m0_bus.rvalid, m1_bus.gnt} !== 3'b011) begin
      bad++;
      $display("FAIL ovl_first got m1rv,m0rv,m1gnt=%b want=011",
               {m1_bus.rvalid, m0_bus.rvalid, m1_bus.gnt});
    end
    advance();
    set_port(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    s_bus.gnt = 1'b0;
    sample();
    total++;
    if ({m1_bus.rvalid, m0_bus.rvalid} !== 2'b10) begin
      bad++;
      $display("FAIL ovl_second got=%b want=10", {m1_bus.rvalid, m0_bus.rvalid});
    end
    advance();
    idle_all();
  endtask

  task automatic test_reset_midop();
    do_reset();
    set_port(0, 1'b1, 32'h0000_7000, 1'b0, 4'hF, 32'h0);
    s_bus.gnt = 1'b1;
    sample();
    advance();
    s_bus.gnt = 1'b0;
    sample();
    advance();
    sample();
    total++;
    if (s_bus.req !== 1'b1 || s_bus.addr !== 32'h0000_7000) begin
      bad++;
      $display("FAIL mid_locked got req=%b addr=%h want req=1 addr=00007000", s_bus.req, s_bus.addr);
    end
    rst_n = 1'b0;
    s_bus.gnt = 1'b1;
    s_bus.rvalid = 1'b1;
    #1;
    model_eval();
    total++;
    if ({s_bus.req, m0_bus.gnt, m1_bus.gnt, m0_bus.rvalid, m1_bus.rvalid} !== 5'b0) begin
      bad++;
      $display("FAIL mid_reset_outputs got=%b want=00000",
               {s_bus.req, m0_bus.gnt, m1_bus.gnt, m0_bus.rvalid, m1_bus.rvalid});
    end
    advance();
    idle_all();
    rst_n = 1'b1;
    for (int c = 0; c <= 2; c++) begin
      set_port(1, (c <= 1), 32'h0000_8000, 1'b0, 4'hF, 32'h0);
      s_bus.gnt    = (c == 1);
      s_bus.rvalid = (c == 2);
      sample();
      total++;
      if ({m1_bus.gnt, m1_bus.rvalid, m0_bus.gnt, m0_bus.rvalid} !== {(c == 1), (c == 2), 2'b00}) begin
        bad++;
        $display("FAIL mid_after c=%0d got=%b want=%b", c,
                 {m1_bus.gnt, m1_bus.rvalid, m0_bus.gnt, m0_bus.rvalid}, {(c == 1), (c == 2), 2'b00});
      end
      advance();
    end
    idle_all();
  endtask

  task automatic test_random();
    bit active[2];
    int waits[2];
    bit g[2];
    do_reset();
    active[0] = 0; active[1] = 0; waits[0] = 0; waits[1] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!active[p] && ($urandom % 3 == 0)) begin
          active[p] = 1;
          waits[p]  = 0;
          set_port(p, 1'b1, $urandom, 1'($urandom % 2), 4'($urandom % 16), $urandom);
        end else if (!active[p]) begin
          set_port(p, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        end
      end
      s_bus.gnt    = 1'b0;
      s_bus.rvalid = (rsp_q.size() > 0) && ($urandom % 2 == 1);
      s_bus.rdata  = $urandom;
      sample();
      if (e_sreq && (rsp_q.size() == 0 || s_bus.rvalid) && ($urandom % 2 == 1)) begin
        s_bus.gnt = 1'b1;
        #1;
        model_eval();
      end
      total++;
      if (s_bus.req !== e_sreq) begin
        bad++;
        $display("FAIL rnd_req cyc=%0d got=%b want=%b", cyc, s_bus.req, e_sreq);
      end
      if (e_sreq) begin
        total++;
        if ({s_bus.addr, s_bus.we, s_bus.be, s_bus.wdata} !== {e_addr, e_we, e_be, e_wdata}) begin
          bad++;
          $display("FAIL rnd_bus cyc=%0d got addr=%h we=%b be=%h wdata=%h want addr=%h we=%b be=%h wdata=%h",
                   cyc, s_bus.addr, s_bus.we, s_bus.be, s_bus.wdata, e_addr, e_we, e_be, e_wdata);
        end
      end
      total++;
      if ({m1_bus.gnt, m0_bus.gnt} !== {e_gnt1, e_gnt0}) begin
        bad++;
        $display("FAIL rnd_gnt cyc=%0d got=%b want=%b", cyc, {m1_bus.gnt, m0_bus.gnt}, {e_gnt1, e_gnt0});
      end
      total++;
      if ({m1_bus.rvalid, m0_bus.rvalid} !== {e_rv1, e_rv0}) begin
        bad++;
        $display("FAIL rnd_rvalid cyc=%0d got=%b want=%b", cyc, {m1_bus.rvalid, m0_bus.rvalid}, {e_rv1, e_rv0});
      end
      if (e_rv0 || e_rv1) begin
        total++;
        if (m0_bus.rdata !== s_bus.rdata || m1_bus.rdata !== s_bus.rdata) begin
          bad++;
          $display("FAIL rnd_rdata cyc=%0d got=%h/%h want=%h", cyc, m0_bus.rdata, m1_bus.rdata, s_bus.rdata);
        end
      end
      g[0] = m0_bus.gnt;
      g[1] = m1_bus.gnt;
      for (int p = 0; p < 2; p++) begin
        if (g[p] && active[1 - p]) begin
          waits[1 - p]++;
          total++;
          if (waits[1 - p] > 1) begin
            bad++;
            $display("FAIL rnd_starve cyc=%0d port=%0d got_waits=%0d want<=1", cyc, 1 - p, waits[1 - p]);
          end
        end
      end
      advance();
      for (int p = 0; p < 2; p++) if (g[p]) active[p] = 0;
    end
    idle_all();
    sample();
    advance();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_single_m0();
    test_round_robin();
    test_lock_hold();
    test_same_cycle_write();
    test_gnt_rvalid_overlap();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
